rx_frame_parser: RTL and testbench

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

---
 rtl/rx_frame_pkg.sv | 22 ++
 rtl/rx_frame_buf.sv | 29 ++
 rtl/rx_frame_parser.sv | 164 ++++++++++++++++
 tb/tb_rx_frame_parser.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared FSM state encoding, error codes and defaults for the rx_frame_parser slice.
package rx_frame_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Index width for a buffer of 'depth' entries; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// rx_frame_buf: payload store, DEPTH x 8 register array with one synchronous
// write port and one combinational read port.
module rx_frame_buf
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; every entry is written before it
    // is read within a frame, so a reset would only add a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: parses SYNC, LEN, payload [, CSUM] byte frames and streams the payload out
// through a valid/ready port. Define PKT_CHECKSUM_EN to require and verify the trailing checksum byte.
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int            AW        = idx_width(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    logic [2:0]    state;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] last_idx;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    rd_data;
    logic          in_frame;
    logic          tmo_hit;
    logic          len_ok;
    logic          buf_we;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign busy     = (state != ST_IDLE);
    assign in_frame = busy && (state != ST_OUT);
    assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    assign len_ok   = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign buf_we   = (state == ST_PAYLOAD) && rx_valid;

    rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_idx),
        .wr_data (rx_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // NOTE: all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            tmo_cnt   <= '0;
            pkt_data  <= 8'h00;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= ERR_NONE;
            overrun   <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            pkt_err <= 1'b0;
            overrun <= 1'b0;
            // Idle-cycle count inside a frame; any received byte restarts it.
            tmo_cnt <= (in_frame && !rx_valid && !tmo_hit) ? tmo_cnt + TW'(1) : '0;

            if (tmo_hit) begin
                pkt_err  <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && (rx_data == SYNC_BYTE)) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            if (len_ok) begin
                                last_idx <= AW'(rx_data - 8'd1);
                                wr_idx   <= '0;
`ifdef PKT_CHECKSUM_EN
                                csum     <= rx_data;
`endif
                                state    <= ST_PAYLOAD;
                            end else begin
                                pkt_err  <= 1'b1;
                                err_code <= ERR_LEN;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
`ifdef PKT_CHECKSUM_EN
                            csum <= csum + rx_data;
`endif
                            if (wr_idx == last_idx) begin
                                rd_idx <= '0;
`ifdef PKT_CHECKSUM_EN
                                state  <= ST_CSUM;
`else
                                state  <= ST_OUT;
`endif
                            end else begin
                                wr_idx <= wr_idx + AW'(1);
                            end
                        end
                    end
`ifdef PKT_CHECKSUM_EN
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if (8'(csum + rx_data) == 8'h00) begin
                                state <= ST_OUT;
                            end else begin
                                pkt_err  <= 1'b1;
                                err_code <= ERR_CSUM;
                                state    <= ST_IDLE;
                            end
                        end
                    end
`endif
                    ST_OUT: begin
                        overrun <= rx_valid;
                        // First cycle in OUT loads byte 0; afterwards each handshake loads the next.
                        if (!pkt_valid || pkt_ready) begin
                            if (pkt_valid && pkt_last) begin
                                pkt_valid <= 1'b0;
                                pkt_last  <= 1'b0;
                                state     <= ST_IDLE;
                            end else begin
                                pkt_valid <= 1'b1;
                                pkt_data  <= rd_data;
                                pkt_last  <= (rd_idx == last_idx);
                                rd_idx    <= rd_idx + AW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: self-checking bench for rx_frame_parser; table vectors, hand-written corner
// sequences and randomized frames scored against a frame-level reference model (follows PKT_CHECKSUM_EN).
module tb_rx_frame_parser;

    localparam logic [7:0] SYNC     = 8'hAA;
    localparam int         MAX_LEN  = 16;
    localparam int         TIMEOUT  = 2000;
`ifdef PKT_CHECKSUM_EN
    localparam bit         CSUM_EN  = 1'b1;
`else
    localparam bit         CSUM_EN  = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [47:0] bytes;   // MSB-first stimulus bytes
        int          nb;
        logic [23:0] pay;     // MSB-first expected payload
        int          np;
        int          err;
        int          nov;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       overrun;
    logic       busy;

    rx_frame_parser #(
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_last  (pkt_last),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass   = 0;
    int         n_checks = 0;
    logic [7:0] mon_data [$];
    bit         mon_last [$];
    int         n_errp   = 0;
    int         n_ovr    = 0;
    logic [1:0] exp_code = 2'd0;

    // Monitor: inputs settle at negedge+1, so at negedge+2 the values the next posedge will see are stable.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (pkt_valid && pkt_ready) begin
                mon_data.push_back(pkt_data);
                mon_last.push_back(pkt_last);
            end
            if (pkt_err) n_errp++;
            if (overrun) n_ovr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_last.delete();
        n_errp = 0;
        n_ovr  = 0;
    endtask

    // Builds SYNC, LEN, payload and (when enabled) a checksum byte; good=0 corrupts the checksum.
    function automatic bq_t make_frame(input logic [7:0] len, input bq_t pay, input bit good);
        bq_t        q;
        logic [7:0] sum;
        q   = {SYNC, len};
        sum = len;
        foreach (pay[i]) begin
            q.push_back(pay[i]);
            sum += pay[i];
        end
        if (CSUM_EN) q.push_back(good ? 8'h00 - sum : 8'h01 - sum);
        return q;
    endfunction

    // Frame-level reference: find the sync, validate the length, collect the payload, verify the sum.
    function automatic void model(input bq_t s, output bq_t pay, output int err);
        int         i;
        logic [7:0] len;
        logic [7:0] sum;
        pay = {};
        err = 0;
        i   = 0;
        while (i < s.size() && s[i] != SYNC) i++;
        if (i + 1 >= s.size()) return;
        len = s[i+1];
        i   = i + 2;
        if (len == 8'd0 || int'(len) > MAX_LEN) begin
            err = 1;
            return;
        end
        sum = len;
        for (int k = 0; k < int'(len); k++) begin
            pay.push_back(s[i+k]);
            sum += s[i+k];
        end
        if (CSUM_EN) begin
            sum += s[i+int'(len)];
            if (sum != 8'h00) begin
                err = 2;
                pay = {};
            end
        end
    endfunction

    task automatic compare_out(input string tag, input bq_t pay, input int err, input int nov);
        int n;
        if (err != 0) exp_code = 2'(err);
        check({tag, " count"}, mon_data.size(), pay.size());
        n = (mon_data.size() < pay.size()) ? mon_data.size() : pay.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s data[%0d]", tag, i), mon_data[i], pay[i]);
            check($sformatf("%s last[%0d]", tag, i), mon_last[i], (i == pay.size() - 1));
        end
        check({tag, " err pulses"}, n_errp, (err != 0) ? 1 : 0);
        check({tag, " err_code"}, err_code, exp_code);
        check({tag, " overruns"}, n_ovr, nov);
    endtask

    task automatic drain(input string tag, input bit rnd);
        for (int k = 0; k < 600 && busy; k++) begin
            if (rnd) pkt_ready = 1'($urandom_range(0, 1));
            step();
        end
        pkt_ready = 1'b1;
        step();
        step();
        check({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic run_frame(input string tag, input bq_t s, input bq_t pay, input int err,
                             input int nov, input bit rnd);
        clear_mon();
        pkt_ready = 1'b1;
        foreach (s[i]) begin
            send_byte(s[i]);
            if (rnd) repeat ($urandom_range(0, 3)) step();
        end
        drain(tag, rnd);
        compare_out(tag, pay, err, nov);
    endtask

    initial begin
        vec_t vt [$];
        bq_t  s;
        bq_t  p;
        int   err;
        int   idle;
        int   trail;

        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pkt_ready = 1'b0;
        step();
        step();
        check("reset pkt_valid", pkt_valid, 1'b0);
        check("reset pkt_last", pkt_last, 1'b0);
        check("reset pkt_err", pkt_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset err_code", err_code, 2'd0);
        check("reset pkt_data", pkt_data, 8'h00);
        rst = 1'b0;
        step();

        // Without the checksum the trailing byte of a frame lands during OUT and is an overrun.
        trail = CSUM_EN ? 0 : 1;
        vt.push_back('{48'hAA00_0000_0000, 2, 24'h000000, 0, 1, 0});
        vt.push_back('{48'hAA03_1122_3397, 6, 24'h112233, 3, 0, trail});
        vt.push_back('{48'hAA03_1122_3396, 6, 24'h112233, CSUM_EN ? 0 : 3, CSUM_EN ? 2 : 0, trail});
        vt.push_back('{48'hAA11_0000_0000, 2, 24'h000000, 0, 1, 0});
        vt.push_back('{48'h55AA_017E_8100, 5, 24'h7E0000, 1, 0, trail});
        vt.push_back('{48'hAA01_5AA5_0000, 4, 24'h5A0000, 1, 0, trail});
        vt.push_back('{48'h00FF_1200_0000, 3, 24'h000000, 0, 0, 0});

        foreach (vt[v]) begin
            s = {};
            p = {};
            for (int j = 0; j < vt[v].nb; j++) s.push_back(vt[v].bytes[47-8*j -: 8]);
            for (int j = 0; j < vt[v].np; j++) p.push_back(vt[v].pay[23-8*j -: 8]);
            run_frame($sformatf("vec%0d", v), s, p, vt[v].err, vt[v].nov, 1'b0);
        end

        // Inter-byte timeout inside the payload.
        clear_mon();
        pkt_ready = 1'b1;
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h44);
        idle = 0;
        while (idle < TIMEOUT + 10) begin
            step();
            idle++;
            if (pkt_err) break;
        end
        check("timeout cycles", idle, TIMEOUT);
        check("timeout err_code", err_code, 2'd3);
        check("timeout busy", busy, 1'b0);
        exp_code = 2'd3;
        step();
        check("timeout pulse width", pkt_err, 1'b0);
        p = {8'h44, 8'h55};
        s = make_frame(8'd2, p, 1'b1);
        model(s, p, err);
        run_frame("after timeout", s, p, err, 0, 1'b0);

        // Back-pressure on byte 1 for five cycles with a byte injected during OUT.
        clear_mon();
        pkt_ready = 1'b1;
        p = {8'hA1, 8'hB2, 8'hC3};
        s = make_frame(8'd3, p, 1'b1);
        foreach (s[i]) send_byte(s[i]);
        check("out entry valid", pkt_valid, 1'b0);
        check("out entry busy", busy, 1'b1);
        step();
        check("valid rise", pkt_valid, 1'b1);
        check("first byte", pkt_data, 8'hA1);
        for (int k = 0; k < 20 && mon_data.size() < 1; k++) step();
        pkt_ready = 1'b0;
        check("hold start data", pkt_data, 8'hB2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) send_byte(8'h3C);
            else step();
            check($sformatf("hold valid %0d", k), pkt_valid, 1'b1);
            check($sformatf("hold data %0d", k), pkt_data, 8'hB2);
            check($sformatf("hold last %0d", k), pkt_last, 1'b0);
        end
        drain("hold", 1'b0);
        compare_out("hold", p, 0, 1);

        // Reset in the middle of a payload.
        clear_mon();
        send_byte(8'hAA);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        check("mid busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst pkt_valid", pkt_valid, 1'b0);
        check("mid rst pkt_last", pkt_last, 1'b0);
        check("mid rst pkt_err", pkt_err, 1'b0);
        check("mid rst overrun", overrun, 1'b0);
        check("mid rst err_code", err_code, 2'd0);
        check("mid rst pkt_data", pkt_data, 8'h00);
        exp_code = 2'd0;
        step();
        rst = 1'b0;
        step();
        p = {8'h0F, 8'hF0, 8'h5A, 8'hC3};
        s = make_frame(8'd4, p, 1'b1);
        model(s, p, err);
        run_frame("after reset", s, p, err, 0, 1'b0);

        // Randomized frames: junk prefix, random length/content/faults, random gaps and back-pressure.
        for (int f = 0; f < 40; f++) begin
            int         kind;
            int         len;
            logic [7:0] b;
            bq_t        pay;
            s    = {};
            pay  = {};
            kind = (f < 2) ? 9 : int'($urandom_range(0, 9));
            len  = (f == 0) ? MAX_LEN : (f == 1) ? 1 : int'($urandom_range(1, MAX_LEN));
            repeat ($urandom_range(0, 2)) begin
                do b = 8'($urandom); while (b == SYNC);
                s.push_back(b);
            end
            if (kind < 2) begin
                s.push_back(SYNC);
                s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
                s = {s, make_frame(8'(len), pay, !(CSUM_EN && kind < 4))};
            end
            model(s, p, err);
            run_frame($sformatf("rand%0d", f), s, p, err, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
